stopwatch_counter: RTL
======================

# stopwatch_counter

Timekeeping core of the stopwatch: produces the `minutes`/`seconds` values consumed by the seven-segment display driver, plus the `pause` level that driver uses for blanking. Counts mm:ss from 00:00 to 59:59 from a single master clock using internal prescalers. Supports pause/resume and an adjust mode that advances the selected field at a faster rate. Sits between the button front-end, which supplies synchronized single-cycle pulses and levels, and the display driver.

## Interface
- `TICK_DIV`, 100000000: master-clock cycles per counting second; must be 2 or more.
- `ADJ_DIV`, 50000000: cycles per adjust-mode increment; must be 2 or more.
- `BLINK_DIV`, 25000000: cycles per `blinkOn` half-period; used only with the macro; must be 2 or more.
- `masterClk` input 1: single clock. All state changes on its rising edge.
- `reset` input 1: synchronous, active-high. Highest priority.
- `pausePulse` input 1: single-cycle request to toggle pause.
- `adjust` input 1: level; 1 selects adjust mode.
- `select` input 1: adjust target; 0 selects minutes, 1 selects seconds.
- `minutes` output 6: registered, range 0–59.
- `seconds` output 6: registered, range 0–59.
- `pause` output 1: registered; 1 while in the PAUSED state.
- `blinkOn` output 1: registered display-enable for blinking.

## Operation
- States: RUN and PAUSED, stored as `pause`. `adjust`=1 is an overlay that suspends normal counting in either state.
- Reset: `minutes`=0, `seconds`=0, `pause`=0 (RUN), `blinkOn`=1, all prescalers cleared to 0.
- Tick prescaler:
  - Counts 0..`TICK_DIV`-1, then wraps to 0.
  - Advances only when in RUN and `adjust`=0.
  - Holds its value while paused.
  - Clears when `adjust` is 1.
- Count on tick, meaning the prescaler is at `TICK_DIV`-1 and the count is enabled:
  - `seconds`+1.
  - At `seconds`=59: `seconds`→0 and `minutes`+1.
  - At 59:59: wrap to 00:00.
- `pausePulse` toggles between RUN and PAUSED.
  - It is honoured even while `adjust`=1; the new state takes effect after adjust exits.
  - A `pausePulse` on the same cycle as a tick takes priority: the tick is dropped, and the prescaler wraps to 0 without incrementing.
- Adjust mode (`adjust`=1):
  - An adjust prescaler counts 0..`ADJ_DIV`-1 and is cleared whenever `adjust`=0.
  - At each wrap, the field chosen by `select` increments and wraps 59→0 with no carry into the other field.
  - A change of `select` applies to the next increment.
- Arithmetic:
  - All fields are 6-bit and never exceed 59.
  - Prescaler widths are derived from their parameters via `$clog2`.

## Timing
- Outputs are registered and update on the edge on which the tick or adjust wrap is detected.
- First `seconds` increment is visible `TICK_DIV` cycles after the cycle in which `reset` is deasserted.
- `pause` changes on the edge that samples `pausePulse`, a 1-cycle latency.
- Resume after pause: remaining prescaler cycles continue, so the elapsed fraction of a second is not lost.
- Adjust entry: first increment `ADJ_DIV` cycles after the first cycle with `adjust`=1.
- Adjust exit: the tick prescaler restarts from 0, so the first tick comes `TICK_DIV` cycles later if in RUN.
- `reset` asserted mid-operation, including mid-adjust or paused, forces the reset values on the next edge and overrides any simultaneous input.

## Configuration
- `STOPWATCH_BLINK_EN` defined:
  - A blink prescaler counts 0..`BLINK_DIV`-1 while `pause`=1 or `adjust`=1.
  - `blinkOn` toggles at each wrap.
  - When neither condition holds, the prescaler clears and `blinkOn` returns to 1 on the next edge.
- `STOPWATCH_BLINK_EN` undefined:
  - `blinkOn` is constant 1.
  - No blink prescaler logic is generated.
- Counting behaviour is identical in both builds.

## Test plan
All scenarios use `TICK_DIV`=4, `ADJ_DIV`=2, `BLINK_DIV`=3.
- Reset, then run 8 cycles → `seconds`=1 after cycle 4 and 2 after cycle 8; `minutes`=0; `pause`=0; `blinkOn`=1.
- Preload to 59:58 via adjust, then run 8 cycles → 59:59, then 00:00.
- In RUN at prescaler=2, pulse `pausePulse`, wait 10 cycles, pulse again → `seconds` frozen while paused; next increment 1 cycle after the resume edge. Also assert `pausePulse` on a tick cycle → no increment and `pause`=1.
- Set `adjust`=1, `select`=1, with `seconds`=58 and `minutes`=3 → `seconds` goes 59 then 0 on successive 2-cycle intervals, `minutes` stays 3. Switch `select` to 0 → `minutes` goes to 4 two cycles later.
- Assert `reset` for one cycle mid-adjust at 12:34 with `pause`=1 → next edge shows 00:00, `pause`=0, `blinkOn`=1; first tick 4 cycles later.
- With `STOPWATCH_BLINK_EN` defined, pause → `blinkOn` toggles 1→0→1 every 3 cycles; resume → `blinkOn`=1 on the next edge. Undefined → `blinkOn` stays 1 throughout.

Source files
------------

// File: rtl/stopwatch_counter_if.sv
// ============================================================================
// Module   : stopwatch_counter_if
// Purpose  : Control and display bundle between the button front-end, the
//            stopwatch timekeeping core and the seven-segment display driver.
// Signals  : pausePulse - single-cycle request to toggle pause
//            adjust     - level, 1 selects adjust mode
//            select     - adjust target, 0 = minutes, 1 = seconds
//            minutes    - 6-bit minutes value, 0..59
//            seconds    - 6-bit seconds value, 0..59
//            pause      - 1 while the stopwatch is paused
//            blinkOn    - display enable used for blinking
// Modports : master - front-end / display side (drives controls)
//            slave  - timekeeping core (drives time and status)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stopwatch_counter_if;
    logic       pausePulse;
    logic       adjust;
    logic       select;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       pause;
    logic       blinkOn;

    modport master (
        output pausePulse,
        output adjust,
        output select,
        input  minutes,
        input  seconds,
        input  pause,
        input  blinkOn
    );

    modport slave (
        input  pausePulse,
        input  adjust,
        input  select,
        output minutes,
        output seconds,
        output pause,
        output blinkOn
    );
endinterface

`default_nettype wire

// File: rtl/stopwatch_counter.sv
// ============================================================================
// Module   : stopwatch_counter
// Purpose  : mm:ss stopwatch core counting 00:00..59:59 from a single master
//            clock through internal prescalers. Supports pause/resume and an
//            adjust mode that advances the selected field at a faster rate.
// Ports    : masterClk - master clock, rising edge
//            reset     - synchronous, active-high, highest priority
//            sw        - stopwatch_counter_if.slave (controls in, time out)
// Params   : TICK_DIV  - clock cycles per counted second (>= 2)
//            ADJ_DIV   - clock cycles per adjust increment (>= 2)
//            BLINK_DIV - clock cycles per blinkOn half-period (>= 2)
// Macro    : STOPWATCH_BLINK_EN - when defined, blinkOn blinks while paused
//            or adjusting; when undefined, blinkOn is constant 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_counter #(
    parameter int TICK_DIV  = 100000000,
    parameter int ADJ_DIV   = 50000000,
    parameter int BLINK_DIV = 25000000
) (
    input  wire logic           masterClk,
    input  wire logic           reset,
    stopwatch_counter_if.slave  sw
);

    localparam int c_TICK_W = $clog2(TICK_DIV);
    localparam int c_ADJ_W  = $clog2(ADJ_DIV);

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_ADJ_W-1:0]  c_ADJ_LAST  = c_ADJ_W'(ADJ_DIV - 1);
    localparam logic [5:0]          c_FIELD_MAX = 6'd59;

    // Elaboration-time guard against illegal divider settings.
    if (TICK_DIV < 2 || ADJ_DIV < 2 || BLINK_DIV < 2) begin : g_bad_params
        $error("stopwatch_counter: all divider parameters must be >= 2");
    end

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [c_TICK_W-1:0] tick_q,  tick_d;
    logic [c_ADJ_W-1:0]  adj_q,   adj_d;
    logic [5:0]          minutes_q, minutes_d;
    logic [5:0]          seconds_q, seconds_d;

    logic w_tick_en;
    logic w_tick_wrap;
    logic w_count;
    logic w_adj_wrap;

    // Normal counting only runs in RUN with adjust released.
    assign w_tick_en   = (state_q == ST_RUN) && !sw.adjust;
    assign w_tick_wrap = w_tick_en && (tick_q == c_TICK_LAST);
    // A pause request on the tick cycle swallows that tick.
    assign w_count     = w_tick_wrap && !sw.pausePulse;
    assign w_adj_wrap  = sw.adjust && (adj_q == c_ADJ_LAST);

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        adj_d     = adj_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;

        // Pause toggles are honoured even during adjust; they simply take
        // effect on counting once adjust is released.
        if (sw.pausePulse) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
        end

        // Tick prescaler: cleared by adjust, frozen while paused.
        if (sw.adjust) begin
            tick_d = '0;
        end else if (w_tick_en) begin
            tick_d = w_tick_wrap ? '0 : tick_q + c_TICK_W'(1);
        end

        // Adjust prescaler: only alive while adjust is held.
        if (!sw.adjust) begin
            adj_d = '0;
        end else begin
            adj_d = w_adj_wrap ? '0 : adj_q + c_ADJ_W'(1);
        end

        if (w_count) begin
            if (seconds_q == c_FIELD_MAX) begin
                seconds_d = '0;
                minutes_d = (minutes_q == c_FIELD_MAX) ? 6'd0 : minutes_q + 6'd1;
            end else begin
                seconds_d = seconds_q + 6'd1;
            end
        end else if (w_adj_wrap) begin
            // Adjust increments wrap within their own field, no carry.
            if (sw.select) begin
                seconds_d = (seconds_q == c_FIELD_MAX) ? 6'd0 : seconds_q + 6'd1;
            end else begin
                minutes_d = (minutes_q == c_FIELD_MAX) ? 6'd0 : minutes_q + 6'd1;
            end
        end
    end

    always_ff @(posedge masterClk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            tick_q    <= '0;
            adj_q     <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            adj_q     <= adj_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
        end
    end

    assign sw.minutes = minutes_q;
    assign sw.seconds = seconds_q;
    assign sw.pause   = (state_q == ST_PAUSED);

`ifdef STOPWATCH_BLINK_EN
    localparam int c_BLINK_W = $clog2(BLINK_DIV);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);

    logic [c_BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic                 blink_on_q,  blink_on_d;
    logic                 w_blink_act;

    // Blink while the displayed value is frozen or being edited.
    assign w_blink_act = (state_q == ST_PAUSED) || sw.adjust;

    always_comb begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        if (w_blink_act) begin
            if (blink_cnt_q == c_BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = !blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + c_BLINK_W'(1);
                blink_on_d  = blink_on_q;
            end
        end
    end

    always_ff @(posedge masterClk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign sw.blinkOn = blink_on_q;
`else
    assign sw.blinkOn = 1'b1;
`endif

endmodule

`default_nettype wire
